// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial CLA add/sub controller.
package cla_serial_add_ctrl_pkg;

  // Width of one lookahead slice; the datapath advances this many bits per cycle.
  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand width must split evenly into whole slices and hold at least one.
  function automatic bit width_ok(input int unsigned w);
    return (w >= NIB_W) && ((w % NIB_W) == 0);
  endfunction

endpackage

// File: rtl/cla_serial_add_ctrl_if.sv
// Request/response bus of the serial add/sub controller.
interface cla_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  // Requester/consumer side.
  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/cla_serial_add_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with group generate/propagate.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       gm,
  output logic       pm
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Lookahead carries from per-bit generate/propagate; p = a|b is valid for carry only.
  always_comb begin
    g    = a & b;
    p    = a | b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = a ^ b ^ c[3:0];
    cout = c[4];
    gm   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pm   = &p;
  end
endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer around a single 4-bit CLA slice.
module cla_serial_add_ctrl
  import cla_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_serial_add_ctrl_if.slave bus
);
  localparam int unsigned NIB = WIDTH / NIB_W;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if (!width_ok(WIDTH)) begin : g_width_err
    $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [3:0]       slice_s;
  logic             slice_cout;
  logic             slice_gm;
  logic             slice_pm;
  logic             unused_slice_group;

  cla4_slice u_slice (
    .a    (opa_q[3:0]),
    .b    (opb_q[3:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .gm   (slice_gm),
    .pm   (slice_pm)
  );

  // Group outputs are reserved for a future multi-slice arrangement.
  assign unused_slice_group = &{1'b0, slice_gm, slice_pm};

  // Next-state: load operands on accept, process one nibble per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[NIB_W*int'(cnt_q) +: NIB_W] = slice_s;
        carry_d = slice_cout;
        opa_d   = opa_q >> NIB_W;
        opb_d   = opb_q >> NIB_W;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NIB - 1)) begin
          sum_d[WIDTH] = slice_cout;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears control, carry and the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;

endmodule
